// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: sequential advance, branch/jump/register redirects,
// exception entry/return, and buffering of redirects that arrive during a stall.
// Optional statistics counters are enabled with the PC_SEQ_STAT_EN macro.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [1:0]  br_sel,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_offset,
    input  logic [25:0] br_index,
    input  logic [31:0] br_reg,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic [31:0] pc_add4,
    output logic        redirect_pending,
`ifdef PC_SEQ_STAT_EN
    output logic [31:0] redirect_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic        fetch_fault
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] br_pc_add4_s;
    logic [31:0] target_s;
    logic        redir_ev_s;
    logic        load_tgt_s;

`ifdef PC_SEQ_STAT_EN
    logic [31:0] redirect_cnt_q, redirect_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
`endif

    // Target computation; the reserved selector never counts as a redirect.
    always_comb begin
        br_pc_add4_s = br_pc + 32'd4;
        target_s     = 32'h0000_0000;
        case (br_sel)
            2'b00:   target_s = br_pc_add4_s + br_offset;
            2'b01:   target_s = {br_pc_add4_s[31:28], br_index, 2'b00};
            2'b10:   target_s = br_reg;
            default: target_s = 32'h0000_0000;
        endcase
        redir_ev_s = br_valid & br_taken & (br_sel != 2'b11);
    end

    // Next-state selection in priority order: exception, eret, stall, redirect, buffered, sequential.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q + 32'd4;
        pend_tgt_d = pend_tgt_q;
        load_tgt_s = 1'b0;
        if (exc_req) begin
            pc_d    = EXC_VEC;
            state_d = ST_RUN;
        end else if (eret_req) begin
            pc_d    = epc;
            state_d = ST_RUN;
        end else if (stall) begin
            pc_d = pc_q;
            if (redir_ev_s) begin
                pend_tgt_d = target_s;
                state_d    = ST_PEND;
            end else begin
                state_d = state_q;
            end
        end else if (redir_ev_s) begin
            pc_d       = target_s;
            state_d    = ST_RUN;
            load_tgt_s = 1'b1;
        end else if (state_q == ST_PEND) begin
            pc_d       = pend_tgt_q;
            state_d    = ST_RUN;
            load_tgt_s = 1'b1;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

`ifdef PC_SEQ_STAT_EN
    // Statistics next values; exception and eret edges count as neither.
    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if (load_tgt_s) begin
            redirect_cnt_d = redirect_cnt_q + 32'd1;
        end else begin
            redirect_cnt_d = redirect_cnt_q;
        end
        if (stall && !exc_req && !eret_req) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            redirect_cnt_q <= 32'h0000_0000;
            stall_cnt_q    <= 32'h0000_0000;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign stall_cnt    = stall_cnt_q;
`endif

    // PC, buffered target and state registers; reset discards any buffered target.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            pend_tgt_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    // Fetch address decode: a faulting PC is still presented so the exception unit can report it.
    always_comb begin
        pc               = pc_q;
        pc_add4          = pc_q + 32'd4;
        redirect_pending = (state_q == ST_PEND);
        fetch_fault      = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LIMIT);
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch-stage PC controller for the pipelined CPU. Owns the PC register and decides each cycle whether to advance sequentially, redirect to a branch, jump or register target, or enter or leave the exception vector. Buffers redirects that arrive during a stall so none are lost. Its output PC drives IM and the F/D pipeline register.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
EXC_VEC, 32'h0000_4180, exception/interrupt handler entry.
IM_BASE, 32'h0000_3000, lowest legal fetch address.
IM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
stall  input  1  hold PC (hazard unit); redirects arriving now are buffered
br_valid  input  1  decode-stage control-transfer instruction present this cycle
br_taken  input  1  transfer resolved taken (ignored when br_valid=0)
br_sel  input  2  target kind: 00 offset, 01 index, 10 register, 11 reserved (treated as not taken)
br_pc  input  32  PC of the transfer instruction
br_offset  input  32  sign-extended, <<2 branch offset
br_index  input  26  jump index field
br_reg  input  32  GPR jump target
exc_req  input  1  take exception/interrupt
eret_req  input  1  return from exception
epc  input  32  return address for eret
pc  output  32  current fetch address
pc_add4  output  32  pc + 4, for link paths
redirect_pending  output  1  a buffered target is waiting
fetch_fault  output  1  pc misaligned or outside [IM_BASE, IM_LIMIT]

Behaviour:
- Reset (reset=0 at a clock edge): pc=RESET_PC, pending buffer cleared, state=RUN. After reset: redirect_pending=0; fetch_fault=0 under the default parameters.
- Target compute, 32-bit wrap-around arithmetic, no overflow detection:
  - offset: br_pc + 4 + br_offset.
  - index: {br_pc[31:28] of (br_pc+4), br_index, 2'b00}.
  - register: br_reg.
- Redirect event: br_valid & br_taken & br_sel != 11.
- The delay slot is already in fetch when the transfer resolves, so an accepted target is the next PC directly.
- States:
  - RUN: no buffered target.
  - PEND: target held in pend_tgt; redirect_pending=1.
- Priority each edge, highest first:
  1. exc_req: pc<=EXC_VEC, ignores stall, clears pending, state=RUN.
  2. eret_req: pc<=epc, ignores stall, clears pending, state=RUN.
  3. stall=1: pc holds. A redirect event loads pend_tgt and moves to PEND; a second event while in PEND overwrites pend_tgt.
  4. stall=0 and redirect event: pc<=computed target (overrides any buffered target); state=RUN.
  5. stall=0 and PEND: pc<=pend_tgt; state=RUN.
  6. Otherwise: pc<=pc+4.
- exc_req and eret_req together: exc_req wins.
- Latency: one cycle from an accepted event to the new pc. A buffered target appears on the first edge where stall=0.
- fetch_fault is combinational from pc: pc[1:0]!=0, or pc<IM_BASE, or pc>IM_LIMIT. The PC still loads the faulting value; the exception unit raises AdEL and asserts exc_req.
- pc_add4 = pc+4, combinational, wraps at 32'hFFFF_FFFC -> 0.
- Reset asserted mid-PEND: the buffered target is discarded.

Optional Feature:
PC_SEQ_STAT_EN
- Defined: adds output ports redirect_cnt[31:0] and stall_cnt[31:0].
  - redirect_cnt counts edges where pc is loaded from a branch, jump or register target (direct or buffered), excluding exc/eret.
  - stall_cnt counts edges with stall=1 and no exc/eret.
  - Both clear on reset and wrap at 2^32.
- Undefined: neither port nor counter exists. Core behaviour is identical.

Test Plan:
- Reset then 3 free-running clocks -> pc = 3000, 3004, 3008, 300C; redirect_pending=0.
- br_pc=3008, offset sel, br_offset=32'hFFFF_FFF8, taken, stall=0 -> next pc=3004.
- stall=1 with jr br_reg=3400 for one cycle, stall held 2 more cycles -> pc frozen, redirect_pending=1; first edge with stall=0 gives pc=3400, pending=0.
- exc_req and eret_req together while in PEND -> pc=4180, pending cleared; next eret_req with epc=3010 -> pc=3010.
- jr br_reg=3002 -> pc=3002 and fetch_fault=1; br_reg=7000 -> fetch_fault=1.
- j from br_pc=3000, br_index=26'h0000C10 -> pc=3040; with PC_SEQ_STAT_EN, redirect_cnt increments by 1.
